// File: rtl/rv32i_decode_pkg.sv
// Shared opcode constants and the decoded-entry record for the RV32I decode stage.
package rv32i_decode_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // PC is carried beside this record because its width is a top-level parameter.
    typedef struct packed {
        logic [19:0] imm_field;
        logic        i_en;
        logic        l_en;
        logic        s_en;
        logic        b_en;
        logic        j_en;
        logic        u_en;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/rv32i_imm_field_pack.sv
// Combinational opcode decode: one-hot type enables, register fields and the
// 20-bit packed immediate consumed by the immediate generator.
module rv32i_imm_field_pack
    import rv32i_decode_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic s;
    assign s = instr[31];

    always_comb begin
        dec        = '0;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        case (instr[6:0])
            OP_IMM, OP_JALR: begin
                dec.i_en      = 1'b1;
                dec.imm_field = {{8{s}}, instr[31:20]};
            end
            OP_LOAD: begin
                dec.l_en      = 1'b1;
                dec.imm_field = {{8{s}}, instr[31:20]};
            end
            OP_STORE: begin
                dec.s_en      = 1'b1;
                dec.imm_field = {{8{s}}, instr[31:25], instr[11:7]};
            end
            // Branch field is already the byte offset (low zero included).
            OP_BRANCH: begin
                dec.b_en      = 1'b1;
                dec.imm_field = {{7{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            // Jump field omits the low zero; the generator appends it.
            OP_JAL: begin
                dec.j_en      = 1'b1;
                dec.imm_field = {instr[31], instr[19:12], instr[20], instr[30:21]};
            end
            OP_LUI, OP_AUIPC: begin
                dec.u_en      = 1'b1;
                dec.imm_field = instr[31:12];
            end
            OP_REG: ;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage with a 2-entry (main + skid) output buffer.
// Optional ILLEGAL_TRAP_EN adds sticky illegal_seen and a saturating illegal_cnt.
module rv32i_decode_stage
    import rv32i_decode_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IMM_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [IMM_W-1:0] out_imm_field,
    output logic             out_i_en,
    output logic             out_l_en,
    output logic             out_s_en,
    output logic             out_b_en,
    output logic             out_j_en,
    output logic             out_u_en,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic             out_illegal
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_seen,
    output logic [7:0]       illegal_cnt
`endif
);

    decode_t          dec;
    decode_t          main_q, main_d, skid_q, skid_d;
    logic [PC_W-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic             accept, drain;

    rv32i_imm_field_pack u_pack (
        .instr (in_instr),
        .dec   (dec)
    );

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain || !main_valid_q) begin
            // Main slot frees up: skid has precedence (in_ready is low whenever skid holds data).
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_pc_d    = in_pc;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign out_pc        = main_pc_q;
    assign out_imm_field = main_q.imm_field;
    assign out_i_en      = main_q.i_en;
    assign out_l_en      = main_q.l_en;
    assign out_s_en      = main_q.s_en;
    assign out_b_en      = main_q.b_en;
    assign out_j_en      = main_q.j_en;
    assign out_u_en      = main_q.u_en;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_funct3    = main_q.funct3;
    assign out_funct7    = main_q.funct7;
    assign out_illegal   = main_q.illegal;

`ifdef ILLEGAL_TRAP_EN
    logic       illegal_seen_q, illegal_seen_d;
    logic [7:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_seen_d = illegal_seen_q;
        illegal_cnt_d  = illegal_cnt_q;
        if (drain && main_q.illegal) begin
            illegal_seen_d = 1'b1;
            if (illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen_q <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign illegal_seen = illegal_seen_q;
    assign illegal_cnt  = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed self-checking bench for rv32i_decode_stage (handles ILLEGAL_TRAP_EN builds).
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [19:0] out_imm_field;
    logic        out_i_en, out_l_en, out_s_en, out_b_en, out_j_en, out_u_en;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_seen;
    logic [7:0]  illegal_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_decode_stage #(.PC_W(32), .IMM_W(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_imm_field (out_imm_field),
        .out_i_en      (out_i_en),
        .out_l_en      (out_l_en),
        .out_s_en      (out_s_en),
        .out_b_en      (out_b_en),
        .out_j_en      (out_j_en),
        .out_u_en      (out_u_en),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_illegal   (out_illegal)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_seen  (illegal_seen),
        .illegal_cnt   (illegal_cnt)
`endif
    );

    logic [5:0]  ens;
    logic [31:0] gen_out;
    assign ens = {out_i_en, out_l_en, out_s_en, out_b_en, out_j_en, out_u_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_imm", out_imm_field, 0);
        chk("reset_pc", out_pc, 0);
        chk("reset_ens", ens, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("reset_seen", illegal_seen, 0);
        chk("reset_cnt", illegal_cnt, 0);
`endif

        // Streaming decode, one instruction per cycle
        out_ready = 1'b1;
        push(32'hFFF00093, 32'h100);                 // addi x1,x0,-1
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_ens", ens, 6'b100000);
        chk("addi_imm", out_imm_field, 20'hFFFFF);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_illegal", out_illegal, 0);
        chk("addi_pc", out_pc, 32'h100);
        push(32'h0020A423, 32'h104);                 // sw x2,8(x1)
        tick();
        chk("sw_ens", ens, 6'b001000);
        chk("sw_imm", out_imm_field, 20'h00008);
        chk("sw_rs1", out_rs1, 1);
        chk("sw_rs2", out_rs2, 2);
        chk("sw_funct3", out_funct3, 2);
        chk("sw_pc", out_pc, 32'h104);
        push(32'h001000EF, 32'h108);                 // jal x1,+2048
        tick();
        gen_out = {{11{out_imm_field[19]}}, out_imm_field, 1'b0};
        chk("jal_ens", ens, 6'b000010);
        chk("jal_imm", out_imm_field, 20'h00400);
        chk("jal_gen_out", gen_out, 32'h00000800);
        chk("jal_rd", out_rd, 1);
        push(32'h00208863, 32'h10C);                 // beq x1,x2,+16
        tick();
        chk("beq_ens", ens, 6'b000100);
        chk("beq_imm", out_imm_field, 20'h00010);
        push(32'h123452B7, 32'h110);                 // lui x5,0x12345
        tick();
        chk("lui_ens", ens, 6'b000001);
        chk("lui_imm", out_imm_field, 20'h12345);
        chk("lui_rd", out_rd, 5);
        push(32'h002081B3, 32'h114);                 // add x3,x1,x2
        tick();
        chk("add_ens", ens, 0);
        chk("add_illegal", out_illegal, 0);
        chk("add_imm", out_imm_field, 0);
        chk("add_rd", out_rd, 3);
        chk("add_valid", out_valid, 1);
        push(32'h0080A183, 32'h118);                 // lw x3,8(x1)
        tick();
        chk("lw_ens", ens, 6'b010000);
        chk("lw_imm", out_imm_field, 20'h00008);
        push(32'h000080E7, 32'h11C);                 // jalr x1,0(x1)
        tick();
        chk("jalr_ens", ens, 6'b100000);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", out_valid, 0);

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        push(32'hFFF00093, 32'h200);
        tick();
        chk("bp_ready_after_1", in_ready, 1);
        push(32'h0020A423, 32'h204);
        tick();
        chk("bp_ready_after_2", in_ready, 0);
        chk("bp_hold_pc_1", out_pc, 32'h200);
        push(32'h123452B7, 32'h208);
        tick();
        chk("bp_ready_stall", in_ready, 0);
        chk("bp_hold_pc_2", out_pc, 32'h200);
        chk("bp_hold_imm", out_imm_field, 20'hFFFFF);
        out_ready = 1'b1;
        tick();
        chk("bp_order_b_pc", out_pc, 32'h204);
        chk("bp_order_b_s", out_s_en, 1);
        chk("bp_ready_reopen", in_ready, 1);
        tick();
        chk("bp_order_c_pc", out_pc, 32'h208);
        chk("bp_order_c_u", out_u_en, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);

        // Flush with main and skid occupied, and with a concurrent illegal input
        out_ready = 1'b0;
        push(32'hFFF00093, 32'h300);
        tick();
        push(32'h0020A423, 32'h304);
        tick();
        chk("fl_full", in_ready, 0);
        push(32'h0000007F, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        push(32'h0000007F, 32'h30C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_drop_input", out_valid, 0);

        // Illegal opcode travels like any other entry
        out_ready = 1'b1;
        push(32'h0000007F, 32'h310);
        tick();
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_flag", out_illegal, 1);
        chk("ill_ens", ens, 0);
        chk("ill_imm", out_imm_field, 0);
        tick();
        chk("ill_drained", out_valid, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_seen", illegal_seen, 1);
        chk("ill_cnt", illegal_cnt, 1);
`endif

        // Asynchronous reset while stalled with both entries full
        out_ready = 1'b0;
        push(32'hFFF00093, 32'h400);
        tick();
        push(32'h0020A423, 32'h404);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_full", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        chk("ar_imm", out_imm_field, 0);
        chk("ar_ens", ens, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("ar_seen", illegal_seen, 0);
        chk("ar_cnt", illegal_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_post_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
